// File: rtl/gobou_ctrl_act_pipe.sv
// gobou_ctrl_act_pipe: control-delay stage for the gobou activation unit.
// Delays start/valid/stop by DEPTH enabled cycles, taps an output-register
// enable at stage OE_TAP, tracks frames in flight and counts output beats.
// Optional protocol checker: define GOBOU_ACT_PROTO_CHK_EN to build the
// sticky err flag; otherwise err is tied low.
// Control bus bit order on in_ctrl/out_ctrl: [2]=start, [1]=valid, [0]=stop.
// Legal ranges: DEPTH 2..16, OE_TAP 0..DEPTH-1.
module gobou_ctrl_act_pipe #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned OE_TAP = DEPTH - 2,
    parameter int unsigned CNT_W  = 16
) (
    input  logic             clk,
    input  logic             xrst,
    input  logic             en,
    input  logic [2:0]       in_ctrl,
    output logic [2:0]       out_ctrl,
    output logic             act_oe,
    output logic             busy,
    output logic             frame_done,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             err
);

    localparam int unsigned CTRL_W    = 3;
    localparam int unsigned BIT_START = 2;
    localparam int unsigned BIT_VALID = 1;
    localparam int unsigned BIT_STOP  = 0;
    localparam int unsigned NFR_W     = $clog2(DEPTH + 2);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    logic [CTRL_W-1:0] stage_q [DEPTH];
    logic [NFR_W-1:0]  nfr_q;
    logic [NFR_W-1:0]  nfr_d;
    state_t            state_q;
    state_t            state_d;

    logic in_s;
    logic in_p;
    logic out_s;
    logic out_p;
    logic out_v;

    // Control shift register; frozen entirely while stalled.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else if (en) begin
            stage_q[0] <= in_ctrl;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    // Outputs are gated by en so nothing leaks downstream during a stall.
    assign out_ctrl   = stage_q[DEPTH-1] & {CTRL_W{en}};
    assign act_oe     = stage_q[OE_TAP][BIT_VALID] & en;
    assign frame_done = out_p;
    assign busy       = (state_q != ST_IDLE);

    // Frame boundary events at the pipe input and output.
    assign in_s  = in_ctrl[BIT_START] & en;
    assign in_p  = in_ctrl[BIT_STOP] & en;
    assign out_s = out_ctrl[BIT_START];
    assign out_p = out_ctrl[BIT_STOP];
    assign out_v = out_ctrl[BIT_VALID];

    // Frames-in-flight next value, saturating in both directions.
    always_comb begin
        nfr_d = nfr_q;
        if (in_s && !out_p) begin
            if (nfr_q != {NFR_W{1'b1}}) begin
                nfr_d = nfr_q + NFR_W'(1);
            end
        end else if (!in_s && out_p) begin
            if (nfr_q != '0) begin
                nfr_d = nfr_q - NFR_W'(1);
            end
        end
    end

    // Frames-in-flight register.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            nfr_q <= '0;
        end else begin
            nfr_q <= nfr_d;
        end
    end

    // Frame-tracking FSM state register.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Frame-tracking FSM next state; holds while stalled.
    always_comb begin
        state_d = state_q;
        if (en) begin
            case (state_q)
                ST_IDLE: begin
                    if (in_s && in_p) begin
                        state_d = ST_DRAIN;
                    end else if (in_s) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (in_p) begin
                        state_d = ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (in_s) begin
                        state_d = in_p ? ST_DRAIN : ST_RUN;
                    end else if (nfr_d == '0) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output beat counter: restarts on each output start, saturates, holds.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            beat_cnt <= '0;
        end else if (out_s) begin
            beat_cnt <= out_v ? CNT_W'(1) : CNT_W'(0);
        end else if (out_v && (beat_cnt != {CNT_W{1'b1}})) begin
            beat_cnt <= beat_cnt + CNT_W'(1);
        end
    end

`ifdef GOBOU_ACT_PROTO_CHK_EN
    logic proto_viol;
    logic err_q;

    // Upstream protocol violations; offending bits are still forwarded.
    always_comb begin
        proto_viol = (in_s && (state_q == ST_RUN))
                   || (in_ctrl[BIT_VALID] && en && (state_q == ST_IDLE) && !in_s)
                   || (in_p && (state_q != ST_RUN) && !in_s)
                   || (!en && (|in_ctrl));
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk or negedge xrst) begin
        if (!xrst) begin
            err_q <= 1'b0;
        end else if (proto_viol) begin
            err_q <= 1'b1;
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_gobou_ctrl_act_pipe.sv
// Directed bench for gobou_ctrl_act_pipe: DEPTH=2 (default tap) and
// DEPTH=8/OE_TAP=3 instances share the stimulus; each test checks one of them.
// Per-cycle stimulus and expectations are bit masks indexed by cycle number.
module tb_gobou_ctrl_act_pipe;

    logic        clk = 1'b0;
    logic        xrst;
    logic        en;
    logic [2:0]  in_ctrl;

    logic [2:0]  o2_ctrl;
    logic        o2_oe;
    logic        o2_busy;
    logic        o2_fd;
    logic [15:0] o2_cnt;
    logic        o2_err;

    logic [2:0]  o8_ctrl;
    logic        o8_oe;
    logic        o8_busy;
    logic        o8_fd;
    logic [15:0] o8_cnt;
    logic        o8_err;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gobou_ctrl_act_pipe u_d2 (
        .clk        (clk),
        .xrst       (xrst),
        .en         (en),
        .in_ctrl    (in_ctrl),
        .out_ctrl   (o2_ctrl),
        .act_oe     (o2_oe),
        .busy       (o2_busy),
        .frame_done (o2_fd),
        .beat_cnt   (o2_cnt),
        .err        (o2_err)
    );

    gobou_ctrl_act_pipe #(.DEPTH(8), .OE_TAP(3)) u_d8 (
        .clk        (clk),
        .xrst       (xrst),
        .en         (en),
        .in_ctrl    (in_ctrl),
        .out_ctrl   (o8_ctrl),
        .act_oe     (o8_oe),
        .busy       (o8_busy),
        .frame_done (o8_fd),
        .beat_cnt   (o8_cnt),
        .err        (o8_err)
    );

    task automatic do_reset();
        xrst    = 1'b0;
        en      = 1'b1;
        in_ctrl = 3'b000;
        repeat (2) @(posedge clk);
        @(negedge clk);
        xrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [7:0] obs;
        xrst    = 1'b0;
        en      = 1'b1;
        in_ctrl = 3'b111;
        #1;
        @(posedge clk);
        #1;
        obs = {o2_ctrl, o2_oe, o2_busy, o2_fd, o2_err};
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_d2_outs: got %b want 00000000", obs);
        end
        n_cmp++;
        if (o2_cnt !== 16'd0 || o8_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL reset_beat_cnt: got %0d/%0d want 0/0", o2_cnt, o8_cnt);
        end
        obs = {o8_ctrl, o8_oe, o8_busy, o8_fd, o8_err};
        n_cmp++;
        if (obs !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_d8_outs: got %b want 00000000", obs);
        end
        in_ctrl = 3'b000;
        @(negedge clk);
        xrst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic();
        logic [15:0] st = 16'h0001, vl = 16'h000F, sp = 16'h0008, em = 16'hFFFF;
        logic [15:0] es = 16'h0004, ev = 16'h003C, ep = 16'h0020;
        logic [15:0] eo = 16'h001E, ef = 16'h0020, eb = 16'h003E;
        logic [5:0]  obs, exp;
        do_reset();
        for (int c = 0; c < 8; c++) begin
            in_ctrl = {st[c], vl[c], sp[c]};
            en      = em[c];
            @(negedge clk);
            obs = {o2_ctrl, o2_oe, o2_fd, o2_busy};
            exp = {es[c], ev[c], ep[c], eo[c], ef[c], eb[c]};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL basic c%0d {s,v,p,oe,fd,busy}: got %b want %b", c, obs, exp);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (o2_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL basic_beat_cnt: got %0d want 4", o2_cnt);
        end
        n_cmp++;
        if (o2_err !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_err: got %b want 0", o2_err);
        end
    endtask

    task automatic test_stall();
        logic [15:0] st = 16'h0001, vl = 16'h0063, sp = 16'h0040, em = 16'hFFE3;
        logic [15:0] es = 16'h0020, ev = 16'h01E0, ep = 16'h0100;
        logic [15:0] eo = 16'h00E2, ef = 16'h0100, eb = 16'h01FE;
        logic [5:0]  obs, exp;
        do_reset();
        for (int c = 0; c < 11; c++) begin
            in_ctrl = {st[c], vl[c], sp[c]};
            en      = em[c];
            @(negedge clk);
            obs = {o2_ctrl, o2_oe, o2_fd, o2_busy};
            exp = {es[c], ev[c], ep[c], eo[c], ef[c], eb[c]};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL stall c%0d {s,v,p,oe,fd,busy}: got %b want %b", c, obs, exp);
            end
            @(posedge clk);
            #1;
        end
        en = 1'b1;
        n_cmp++;
        if (o2_cnt !== 16'd4) begin
            n_bad++;
            $display("FAIL stall_beat_cnt: got %0d want 4", o2_cnt);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] st = 16'h0009, vl = 16'h003F, sp = 16'h0024, em = 16'hFFFF;
        logic [15:0] es = 16'h0024, ev = 16'h00FC, ep = 16'h0090;
        logic [15:0] eo = 16'h007E, ef = 16'h0090, eb = 16'h00FE;
        logic [5:0]  obs, exp;
        do_reset();
        for (int c = 0; c < 9; c++) begin
            in_ctrl = {st[c], vl[c], sp[c]};
            en      = em[c];
            @(negedge clk);
            obs = {o2_ctrl, o2_oe, o2_fd, o2_busy};
            exp = {es[c], ev[c], ep[c], eo[c], ef[c], eb[c]};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL b2b c%0d {s,v,p,oe,fd,busy}: got %b want %b", c, obs, exp);
            end
            if (c == 4) begin
                n_cmp++;
                if (u_d2.nfr_q !== 2'd2) begin
                    n_bad++;
                    $display("FAIL b2b_nfr_peak: got %0d want 2", u_d2.nfr_q);
                end
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (o2_cnt !== 16'd3) begin
            n_bad++;
            $display("FAIL b2b_beat_cnt: got %0d want 3", o2_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [6:0] obs;
        do_reset();
        in_ctrl = 3'b110;
        @(posedge clk);
        #1;
        in_ctrl = 3'b010;
        @(posedge clk);
        #1;
        in_ctrl = 3'b010;
        #2;
        xrst = 1'b0;
        #1;
        obs = {o2_ctrl, o2_oe, o2_fd, o2_busy, o2_err};
        n_cmp++;
        if (obs !== 7'd0 || o2_cnt !== 16'd0) begin
            n_bad++;
            $display("FAIL rst_mid_async: got %b cnt %0d want 0000000 cnt 0", obs, o2_cnt);
        end
        in_ctrl = 3'b000;
        @(negedge clk);
        xrst = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            obs = {o2_ctrl, o2_oe, o2_fd, o2_busy, o2_err};
            n_cmp++;
            if (obs !== 7'd0) begin
                n_bad++;
                $display("FAIL rst_mid_after c%0d: got %b want 0000000", c, obs);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_depth8_single();
        logic [15:0] st = 16'h0001, vl = 16'h0001, sp = 16'h0001;
        logic [15:0] es = 16'h0100, ev = 16'h0100, ep = 16'h0100;
        logic [15:0] eo = 16'h0010, ef = 16'h0100, eb = 16'h01FE;
        logic [5:0]  obs, exp;
        do_reset();
        for (int c = 0; c < 10; c++) begin
            in_ctrl = {st[c], vl[c], sp[c]};
            en      = 1'b1;
            @(negedge clk);
            obs = {o8_ctrl, o8_oe, o8_fd, o8_busy};
            exp = {es[c], ev[c], ep[c], eo[c], ef[c], eb[c]};
            n_cmp++;
            if (obs !== exp) begin
                n_bad++;
                $display("FAIL d8_single c%0d {s,v,p,oe,fd,busy}: got %b want %b", c, obs, exp);
            end
            @(posedge clk);
            #1;
        end
        n_cmp++;
        if (o8_cnt !== 16'd1) begin
            n_bad++;
            $display("FAIL d8_beat_cnt: got %0d want 1", o8_cnt);
        end
    endtask

    task automatic test_proto_err();
        logic [15:0] st = 16'h0005, vl = 16'h000F, sp = 16'h0008;
        logic        exp_err;
`ifdef GOBOU_ACT_PROTO_CHK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        do_reset();
        for (int c = 0; c < 8; c++) begin
            in_ctrl = {st[c], vl[c], sp[c]};
            en      = 1'b1;
            @(negedge clk);
            if (c == 2) begin
                n_cmp++;
                if (o2_err !== 1'b0) begin
                    n_bad++;
                    $display("FAIL err_before_edge: got %b want 0", o2_err);
                end
            end
            if (c == 3 || c == 7) begin
                n_cmp++;
                if (o2_err !== exp_err) begin
                    n_bad++;
                    $display("FAIL err_sticky c%0d: got %b want %b", c, o2_err, exp_err);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        xrst    = 1'b0;
        en      = 1'b1;
        in_ctrl = 3'b000;
        test_reset();
        test_basic();
        test_stall();
        test_back_to_back();
        test_reset_mid_frame();
        test_depth8_single();
        test_proto_err();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
